// File: rtl/ahb_sram_slave.sv
// AHB-Lite memory subordinate backed by a register array.
// Handles byte/halfword/word writes, programmable wait states and the
// two-cycle ERROR response. Outputs depend only on registered state.
module ahb_sram_slave #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [WIDTH-1:0] HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [WIDTH-1:0] HRDATA
);

  localparam int BYTES   = WIDTH / 8;
  localparam int OFF_W   = $clog2(BYTES);
  localparam int OFF_W_S = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W_R = $clog2(DEPTH);
  localparam int IDX_W   = (IDX_W_R > 0) ? IDX_W_R : 1;
  localparam int CNT_W   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [31:0]        IDX_MASK = (32'd1 << IDX_W) - 32'd1;
  localparam logic [OFF_W_S-1:0] OFF_MASK = OFF_W_S'(BYTES - 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_nextCnt;
  logic [IDX_W-1:0]     r_index;
  logic [OFF_W_S-1:0]   r_off;
  logic [2:0]           r_size;
  logic                 r_write;
  logic [WIDTH-1:0]     r_mem [DEPTH];

  logic [31:0]          w_idx32;
  logic                 w_error;
  logic                 w_canAccept;
  logic                 w_accept;
  logic                 w_complete;
  logic [BYTES-1:0]     w_laneEn;
  logic                 w_unused;

  // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ, which are treated alike.
  assign w_unused = HTRANS[0];

  // Word index covers only the decoded address bits; anything past DEPTH is illegal.
  assign w_idx32 = (HADDR >> OFF_W) & IDX_MASK;
  assign w_error = (32'(HSIZE) > 32'(OFF_W)) ||
                   ((HADDR & ((32'd1 << HSIZE) - 32'd1)) != 32'd0) ||
                   (w_idx32 >= 32'(DEPTH));

  // A new address phase may only be taken when the current data phase is ending.
  assign w_canAccept = (r_state == ST_IDLE) || (r_state == ST_ERR2) ||
                       ((r_state == ST_DATA) && (r_cnt == '0));
  assign w_accept    = HSEL && HREADY && HTRANS[1] && w_canAccept;
  assign w_complete  = (r_state == ST_DATA) && (r_cnt == '0) && HREADY;

  // Next-state, wait counter and response outputs.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    HRDATA      = '0;
    case (r_state)
      ST_DATA: begin
        HREADYOUT = (r_cnt == '0);
        HRDATA    = r_mem[r_index];
        if (r_cnt != '0) begin
          w_nextCnt = r_cnt - 1'b1;
        end else if (HREADY) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_ERR1: begin
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        w_nextState = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP = 1'b1;
        if (HREADY) begin
          w_nextState = ST_IDLE;
        end
      end
      default: ;
    endcase
    if (w_accept) begin
      w_nextState = w_error ? ST_ERR1 : ST_DATA;
      w_nextCnt   = w_error ? '0 : CNT_LOAD;
    end
  end

  // Byte lanes touched by the registered transfer, little-endian.
  always_comb begin
    w_laneEn = '0;
    for (int b = 0; b < BYTES; b++) begin
      w_laneEn[b] = (b >= int'(r_off)) && (b < int'(r_off) + (1 << r_size));
    end
  end

  // State, counter and address-phase capture; reset aborts any transfer.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_index <= '0;
      r_off   <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_accept) begin
        r_index <= w_idx32[IDX_W-1:0];
        r_off   <= HADDR[OFF_W_S-1:0] & OFF_MASK;
        r_size  <= HSIZE;
        r_write <= HWRITE;
      end
    end
  end

  // Memory write at the end of the final data cycle; contents survive reset.
  always_ff @(posedge HCLK) begin
    if (!HRESET && w_complete && r_write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_laneEn[b]) begin
          r_mem[r_index][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances share one bus,
// selected through a small response multiplexor.
module tb_ahb_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        busReady;
  logic        busReadyRaw;
  logic [31:0] rdataBus;

  logic        hsel0, hsel1, hsel2;
  logic        ro0, ro1, ro2;
  logic        resp0, resp1, resp2;
  logic [31:0] rdata0, rdata1, rdata2;

  logic [1:0]  active;
  logic        selOn;
  logic        forceStall;
  logic        busTimeout;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 HCLK = ~HCLK;

  assign hsel0 = selOn && (active == 2'd0);
  assign hsel1 = selOn && (active == 2'd1);
  assign hsel2 = selOn && (active == 2'd2);

  // Response multiplexor keyed by the slave that owns the bus.
  always_comb begin
    busReadyRaw = ro0;
    rdataBus    = rdata0;
    case (active)
      2'd1: begin busReadyRaw = ro1; rdataBus = rdata1; end
      2'd2: begin busReadyRaw = ro2; rdataBus = rdata2; end
      default: ;
    endcase
  end
  assign busReady = busReadyRaw && !forceStall;

  ahb_sram_slave #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(busReady),
    .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rdata0));

  ahb_sram_slave #(.WIDTH(32), .DEPTH(200), .WAIT_STATES(2)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(busReady),
    .HREADYOUT(ro1), .HRESP(resp1), .HRDATA(rdata1));

  ahb_sram_slave #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u_dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(busReady),
    .HREADYOUT(ro2), .HRESP(resp2), .HRDATA(rdata2));

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addrPhase(input logic [1:0] dev, input logic [1:0] trans, input logic wr,
                           input logic [2:0] size, input logic [31:0] addr);
    active = dev;
    selOn  = 1'b1;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
  endtask

  task automatic idleBus();
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] dev, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] data);
    int n;
    addrPhase(dev, 2'b10, 1'b1, size, addr);
    tick();
    idleBus();
    HWDATA = data;
    n = 0;
    while (!busReady && n < 16) begin
      tick();
      n++;
    end
    if (!busReady) busTimeout = 1'b1;
    tick();
    selOn = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] dev, input logic [31:0] addr, output logic [31:0] data);
    int n;
    addrPhase(dev, 2'b10, 1'b0, 3'd2, addr);
    tick();
    idleBus();
    n = 0;
    while (!busReady && n < 16) begin
      tick();
      n++;
    end
    if (!busReady) busTimeout = 1'b1;
    data = rdataBus;
    tick();
    selOn = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
    nCompared++; if ({ro2, ro1, ro0} !== 3'b111) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b expected 111", {ro2, ro1, ro0}); end
    nCompared++; if ({resp2, resp1, resp0} !== 3'b000) begin nMismatched++; $display("[TB] FAIL reset_resp: got %b expected 000", {resp2, resp1, resp0}); end
    nCompared++; if ((rdata0 | rdata1 | rdata2) !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rdata: got %h/%h/%h expected 0", rdata0, rdata1, rdata2); end
  endtask

  task automatic test_zero_wait();
    addrPhase(2'd0, 2'b10, 1'b1, 3'd2, 32'h10);
    nCompared++; if (ro0 !== 1'b1) begin nMismatched++; $display("[TB] FAIL zw_addr_ready: got %b expected 1", ro0); end
    tick();
    HWDATA = 32'hDEADBEEF;
    addrPhase(2'd0, 2'b10, 1'b0, 3'd2, 32'h10);
    nCompared++; if (ro0 !== 1'b1) begin nMismatched++; $display("[TB] FAIL zw_wr_ready: got %b expected 1", ro0); end
    tick();
    idleBus();
    nCompared++; if (ro0 !== 1'b1) begin nMismatched++; $display("[TB] FAIL zw_rd_ready: got %b expected 1", ro0); end
    nCompared++; if (rdata0 !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL zw_rd_data: got %h expected deadbeef", rdata0); end
    nCompared++; if (resp0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL zw_rd_resp: got %b expected 0", resp0); end
    tick();
    nCompared++; if (rdata0 !== 32'h0) begin nMismatched++; $display("[TB] FAIL zw_idle_rdata: got %h expected 0", rdata0); end
    selOn = 1'b0;
  endtask

  task automatic test_byte_lanes();
    addrPhase(2'd0, 2'b10, 1'b1, 3'd2, 32'h20);
    tick();
    HWDATA = 32'h0;
    addrPhase(2'd0, 2'b10, 1'b1, 3'd0, 32'h21);
    tick();
    HWDATA = 32'h5555AA55;
    addrPhase(2'd0, 2'b10, 1'b1, 3'd1, 32'h22);
    tick();
    HWDATA = 32'h12346666;
    addrPhase(2'd0, 2'b10, 1'b0, 3'd2, 32'h20);
    tick();
    idleBus();
    nCompared++; if (rdata0 !== 32'h1234AA00) begin nMismatched++; $display("[TB] FAIL lanes_read: got %h expected 1234aa00", rdata0); end
    tick();
    selOn = 1'b0;
  endtask

  task automatic test_hready_stall();
    addrPhase(2'd0, 2'b10, 1'b0, 3'd2, 32'h10);
    tick();
    idleBus();
    forceStall = 1'b1;
    nCompared++; if (rdata0 !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL stall_data0: got %h expected deadbeef", rdata0); end
    tick();
    nCompared++; if (rdata0 !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL stall_hold: got %h expected deadbeef", rdata0); end
    forceStall = 1'b0;
    tick();
    nCompared++; if (rdata0 !== 32'h0) begin nMismatched++; $display("[TB] FAIL stall_release: got %h expected 0", rdata0); end
    selOn = 1'b0;
  endtask

  task automatic test_wait_states();
    busWrite(2'd1, 32'h10, 3'd2, 32'hCAFEF00D);
    addrPhase(2'd1, 2'b10, 1'b0, 3'd2, 32'h10);
    tick();
    idleBus();
    nCompared++; if (ro1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL ws_cycle1_ready: got %b expected 0", ro1); end
    tick();
    nCompared++; if (ro1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL ws_cycle2_ready: got %b expected 0", ro1); end
    tick();
    nCompared++; if (ro1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL ws_cycle3_ready: got %b expected 1", ro1); end
    nCompared++; if (rdata1 !== 32'hCAFEF00D) begin nMismatched++; $display("[TB] FAIL ws_cycle3_data: got %h expected cafef00d", rdata1); end
    nCompared++; if (resp1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL ws_cycle3_resp: got %b expected 0", resp1); end
    tick();
    nCompared++; if (ro1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL ws_after_ready: got %b expected 1", ro1); end
    selOn = 1'b0;
    nCompared++; if (busTimeout !== 1'b0) begin nMismatched++; $display("[TB] FAIL ws_timeout: got %b expected 0", busTimeout); end
  endtask

  task automatic test_error();
    logic [31:0] addrs [3];
    logic [2:0]  sizes [3];
    logic [31:0] rd;
    addrs[0] = 32'h02;  sizes[0] = 3'd2;
    addrs[1] = 32'h00;  sizes[1] = 3'd3;
    addrs[2] = 32'h320; sizes[2] = 3'd2;
    busWrite(2'd1, 32'h00, 3'd2, 32'h11111111);
    for (int k = 0; k < 3; k++) begin
      addrPhase(2'd1, 2'b10, 1'b1, sizes[k], addrs[k]);
      tick();
      idleBus();
      HWDATA = 32'hFFFFFFFF;
      nCompared++; if ({ro1, resp1} !== 2'b01) begin nMismatched++; $display("[TB] FAIL err%0d_first: got ready/resp %b expected 01", k, {ro1, resp1}); end
      tick();
      nCompared++; if ({ro1, resp1} !== 2'b11) begin nMismatched++; $display("[TB] FAIL err%0d_second: got ready/resp %b expected 11", k, {ro1, resp1}); end
      tick();
      nCompared++; if ({ro1, resp1} !== 2'b10) begin nMismatched++; $display("[TB] FAIL err%0d_after: got ready/resp %b expected 10", k, {ro1, resp1}); end
    end
    busRead(2'd1, 32'h00, rd);
    nCompared++; if (rd !== 32'h11111111) begin nMismatched++; $display("[TB] FAIL err_mem_unchanged: got %h expected 11111111", rd); end
    nCompared++; if (busTimeout !== 1'b0) begin nMismatched++; $display("[TB] FAIL err_timeout: got %b expected 0", busTimeout); end
  endtask

  task automatic test_idle_busy_deselect();
    logic [31:0] rd;
    busWrite(2'd0, 32'h30, 3'd2, 32'h5A5A5A5A);
    for (int k = 0; k < 3; k++) begin
      addrPhase(2'd0, (k == 0) ? 2'b00 : ((k == 1) ? 2'b01 : 2'b10), 1'b1, 3'd2, 32'h30);
      selOn = (k != 2);
      tick();
      idleBus();
      HWDATA = 32'hFFFFFFFF;
      nCompared++; if ({ro0, resp0} !== 2'b10) begin nMismatched++; $display("[TB] FAIL ignore%0d_resp: got ready/resp %b expected 10", k, {ro0, resp0}); end
      nCompared++; if (rdata0 !== 32'h0) begin nMismatched++; $display("[TB] FAIL ignore%0d_rdata: got %h expected 0", k, rdata0); end
      tick();
    end
    selOn = 1'b0;
    busRead(2'd0, 32'h30, rd);
    nCompared++; if (rd !== 32'h5A5A5A5A) begin nMismatched++; $display("[TB] FAIL ignore_mem: got %h expected 5a5a5a5a", rd); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] rd;
    busWrite(2'd2, 32'h40, 3'd2, 32'h0BADCAFE);
    addrPhase(2'd2, 2'b10, 1'b1, 3'd2, 32'h40);
    tick();
    idleBus();
    HWDATA = 32'hFFFFFFFF;
    nCompared++; if (ro2 !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mid_wait: got %b expected 0", ro2); end
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    nCompared++; if ({ro2, resp2} !== 2'b10) begin nMismatched++; $display("[TB] FAIL rst_mid_resp: got ready/resp %b expected 10", {ro2, resp2}); end
    nCompared++; if (rdata2 !== 32'h0) begin nMismatched++; $display("[TB] FAIL rst_mid_rdata: got %h expected 0", rdata2); end
    for (int i = 0; i < 5; i++) tick();
    selOn = 1'b0;
    busRead(2'd2, 32'h40, rd);
    nCompared++; if (rd !== 32'h0BADCAFE) begin nMismatched++; $display("[TB] FAIL rst_mid_mem: got %h expected 0badcafe", rd); end
    nCompared++; if (busTimeout !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mid_timeout: got %b expected 0", busTimeout); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    HRESET     = 1'b1;
    HADDR      = 32'h0;
    HTRANS     = 2'b00;
    HWRITE     = 1'b0;
    HSIZE      = 3'd2;
    HWDATA     = 32'h0;
    active     = 2'd0;
    selOn      = 1'b0;
    forceStall = 1'b0;
    busTimeout = 1'b0;
    test_reset();
    test_zero_wait();
    test_byte_lanes();
    test_hready_stall();
    test_wait_states();
    test_error();
    test_idle_busy_deselect();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite subordinate with a register-array memory. It produces the per-slave response signals HRDATA, HRESP and HREADYOUT that the response multiplexor selects between. It supports byte, halfword and word writes, a configurable number of wait states, and the two-cycle ERROR response for illegal accesses. One instance sits on each memory port of the interconnect, behind the address decoder's HSEL.

## Interface
- `WIDTH`, 32: data bus width in bits; a multiple of 8, at most 64.
- `DEPTH`, 256: number of WIDTH-bit words in the array.
- `WAIT_STATES`, 0: wait cycles (HREADYOUT=0) inserted before an OKAY data phase completes.

Ports:
- `HCLK` in 1: clock, rising edge.
- `HRESET` in 1: reset, synchronous, active-high.
- `HSEL` in 1: slave select from the decoder.
- `HADDR` in 32: byte address. Only the low `$clog2(DEPTH)+$clog2(WIDTH/8)` bits are used.
- `HTRANS` in 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: transfer size, 2^HSIZE bytes.
- `HWDATA` in WIDTH: write data, valid during the data phase.
- `HREADY` in 1: bus-wide ready, fed back from the multiplexor output.
- `HREADYOUT` out 1: this slave's ready.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.
- `HRDATA` out WIDTH: read data.

## Operation
- **Accept condition:** HSEL & HREADY & HTRANS[1] at a rising edge. On accept, register HADDR, HWRITE and HSIZE, and compute the error flag.
- **Ignored transfers:** IDLE and BUSY, or HSEL=0, produce no data phase. The slave stays or returns to IDLE and responds OKAY with zero wait.
- **ERROR is flagged when any of these holds:**
  - HSIZE > $clog2(WIDTH/8);
  - the address is not aligned to 2^HSIZE;
  - the word index HADDR[ADDR_W-1:$clog2(WIDTH/8)] >= DEPTH.
- **State machine (4 states):**
  - IDLE: HREADYOUT=1, HRESP=0. On accept, go to DATA if legal, otherwise ERR1.
  - DATA: the wait counter is loaded with WAIT_STATES on accept. HREADYOUT = (cnt==0), HRESP=0. The counter decrements each cycle while nonzero.
    - In the cycle where cnt==0 the transfer completes.
    - If another accept occurs in that cycle, go to DATA or ERR1 for the new transfer; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Evaluate accept exactly as in the final DATA cycle.
- **Write:** at the edge ending the final DATA cycle, write HWDATA to byte lanes [A, A+2^HSIZE-1], where A = registered HADDR mod (WIDTH/8). Lane ordering is little-endian. Other lanes are unchanged.
- **Read:** in DATA, HRDATA = mem[registered index], the full word regardless of HSIZE. In every other state HRDATA = 0.
- **Errored transfers:** never modify memory.
- **Reset:** HRESET aborts any transfer in flight. Next cycle: state IDLE, cnt 0, HREADYOUT=1, HRESP=0, HRDATA=0. Memory contents are not affected by reset.

## Timing
- **Pipelining:** the address phase of transfer N+1 overlaps the final data cycle of transfer N, so back-to-back zero-wait transfers run at one per cycle.
- **Data phase length:**
  - OKAY: WAIT_STATES+1 cycles.
  - ERROR: exactly 2 cycles. HRESP=1 in both; HREADYOUT is 0 then 1.
- **Read-after-write to the same word, back-to-back:** the write commits at the edge that starts the read's data phase, so the read returns the new data.
- **Outputs are combinational from registers only:** state, cnt, the registered address/control, and the memory array. There is no input-to-output combinational path.
- **Cycles with HREADY=0 caused by another slave:** no accept occurs. A pending DATA or ERR2 completion holds its outputs steady until HREADY=1.
- **Wait-counter width:** max(1, $clog2(WAIT_STATES+1)).

## Test plan
- **Zero-wait word access** (WIDTH=32, WAIT_STATES=0): write 0xDEADBEEF to 0x10, then read 0x10 back-to-back. Required: HREADYOUT stays 1 throughout, and the read data phase gives HRDATA=0xDEADBEEF with HRESP=0.
- **Byte/halfword lanes:** word 0x20 holds 0x00000000. Write byte 0xAA to 0x21, then halfword 0x1234 to 0x22. Required: reading 0x20 returns 0x1234AA00.
- **Wait states** (WAIT_STATES=2): read 0x10. Required: HREADYOUT is 0,0,1 across the data phase, and HRDATA is valid in the third cycle.
- **ERROR response:** issue, one at a time, a misaligned word at 0x02, HSIZE=3, and (with DEPTH=200) index 200 at address 0x320. Required for each: HREADYOUT 0 then 1 with HRESP=1 in both cycles, and memory unchanged.
- **IDLE/BUSY and deselect:** HTRANS=IDLE, BUSY, or HSEL=0 with NONSEQ. Required: HREADYOUT=1, HRESP=0, no write occurs.
- **Reset mid-transfer** (WAIT_STATES=3): assert HRESET one cycle into a write. Required: next cycle HREADYOUT=1, HRESP=0, HRDATA=0, and the target word is unchanged.
